// File: rtl/fifo_write_side.sv
// -----------------------------------------------------------------------------
// fifo_write_side
//   Storage and pointer end of an 8-entry FIFO. Holds the eight data registers,
//   the read/write pointers and the occupancy count, and classifies every clock
//   edge into a status code. The read data path (8-to-1 mux) lives outside this
//   block; it is addressed by rd_ptr and fed from reg0..reg7.
//
// Ports
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset, clears contents immediately
//   wr_en       write request, sampled at posedge clk
//   rd_en       read (pop) request, sampled at posedge clk
//   din         write data
//   reg0..reg7  storage register contents (read mux inputs a..h)
//   rd_ptr      address of the oldest entry (read mux select)
//   wr_ptr      address of the next write slot
//   data_count  occupancy, 0..8
//   full        data_count == 8
//   empty       data_count == 0
//   wr_ack      one-cycle pulse after an accepted write
//   wr_err      one-cycle pulse after a rejected write
//   rd_ack      one-cycle pulse after an accepted read
//   rd_err      one-cycle pulse after a rejected read
//   state       status of the operation decided at the last edge
// -----------------------------------------------------------------------------
module fifo_write_side #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] reg0,
    output logic [WIDTH-1:0] reg1,
    output logic [WIDTH-1:0] reg2,
    output logic [WIDTH-1:0] reg3,
    output logic [WIDTH-1:0] reg4,
    output logic [WIDTH-1:0] reg5,
    output logic [WIDTH-1:0] reg6,
    output logic [WIDTH-1:0] reg7,
    output logic [2:0]       rd_ptr,
    output logic [2:0]       wr_ptr,
    output logic [3:0]       data_count,
    output logic             full,
    output logic             empty,
    output logic             wr_ack,
    output logic             wr_err,
    output logic             rd_ack,
    output logic             rd_err,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_WRITE  = 3'b001,
        ST_READ   = 3'b010,
        ST_WR_ERR = 3'b011,
        ST_RD_ERR = 3'b100,
        ST_RDWR   = 3'b101
    } state_t;

    logic [WIDTH-1:0] mem_r [8];
    logic [2:0]       wr_ptr_r;
    logic [2:0]       rd_ptr_r;
    logic [3:0]       count_r;
    state_t           state_r;
    logic             wr_ack_r;
    logic             wr_err_r;
    logic             rd_ack_r;
    logic             rd_err_r;

    state_t           next_state_s;
    logic             do_wr_s;
    logic             do_rd_s;
    logic             wr_ack_s;
    logic             wr_err_s;
    logic             rd_ack_s;
    logic             rd_err_s;
    logic             full_s;
    logic             empty_s;

    assign full_s  = (count_r == 4'd8);
    assign empty_s = (count_r == 4'd0);

    // Decide this edge's operation from the request pair and pre-edge occupancy.
    always_comb begin
        next_state_s = ST_IDLE;
        do_wr_s      = 1'b0;
        do_rd_s      = 1'b0;
        wr_ack_s     = 1'b0;
        wr_err_s     = 1'b0;
        rd_ack_s     = 1'b0;
        rd_err_s     = 1'b0;
        case ({wr_en, rd_en})
            2'b00: begin
                next_state_s = ST_IDLE;
            end
            2'b10: begin
                if (!full_s) begin
                    next_state_s = ST_WRITE;
                    do_wr_s      = 1'b1;
                    wr_ack_s     = 1'b1;
                end else begin
                    next_state_s = ST_WR_ERR;
                    wr_err_s     = 1'b1;
                end
            end
            2'b01: begin
                if (!empty_s) begin
                    next_state_s = ST_READ;
                    do_rd_s      = 1'b1;
                    rd_ack_s     = 1'b1;
                end else begin
                    next_state_s = ST_RD_ERR;
                    rd_err_s     = 1'b1;
                end
            end
            2'b11: begin
                // At the extremes only the half that can succeed is taken;
                // the other half is flagged but the status names the survivor.
                if (empty_s) begin
                    next_state_s = ST_WRITE;
                    do_wr_s      = 1'b1;
                    wr_ack_s     = 1'b1;
                    rd_err_s     = 1'b1;
                end else if (full_s) begin
                    next_state_s = ST_READ;
                    do_rd_s      = 1'b1;
                    rd_ack_s     = 1'b1;
                    wr_err_s     = 1'b1;
                end else begin
                    next_state_s = ST_RDWR;
                    do_wr_s      = 1'b1;
                    do_rd_s      = 1'b1;
                    wr_ack_s     = 1'b1;
                    rd_ack_s     = 1'b1;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Status register and single-cycle ack/err pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            wr_ack_r <= 1'b0;
            wr_err_r <= 1'b0;
            rd_ack_r <= 1'b0;
            rd_err_r <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            wr_ack_r <= wr_ack_s;
            wr_err_r <= wr_err_s;
            rd_ack_r <= rd_ack_s;
            rd_err_r <= rd_err_s;
        end
    end

    // Storage registers; popped entries keep their stale contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_wr_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap mod 8 through their 3-bit width; count stays in 0..8
    // because the decision logic never accepts a write when full or a read when empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= 3'd0;
            rd_ptr_r <= 3'd0;
            count_r  <= 4'd0;
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + 3'd1;
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + 3'd1;
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   count_r <= count_r + 4'd1;
                2'b01:   count_r <= count_r - 4'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign reg0       = mem_r[0];
    assign reg1       = mem_r[1];
    assign reg2       = mem_r[2];
    assign reg3       = mem_r[3];
    assign reg4       = mem_r[4];
    assign reg5       = mem_r[5];
    assign reg6       = mem_r[6];
    assign reg7       = mem_r[7];
    assign rd_ptr     = rd_ptr_r;
    assign wr_ptr     = wr_ptr_r;
    assign data_count = count_r;
    assign full       = full_s;
    assign empty      = empty_s;
    assign wr_ack     = wr_ack_r;
    assign wr_err     = wr_err_r;
    assign rd_ack     = rd_ack_r;
    assign rd_err     = rd_err_r;
    assign state      = state_r;

endmodule
